// File: rtl/vc_pkg.sv
// Shared types and the nibble combination function for the vc_slice_sched slice.
package vc_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam int NIB_W = 4;

  function automatic logic [NIB_W-1:0] vc_nib(input logic [NIB_W-1:0] a,
                                              input logic [NIB_W-1:0] b);
    logic [NIB_W-1:0] c;
    c[0] = ~a[0];
    c[1] = ~b[0];
    c[2] = ~b[1];
    c[3] = ~((a[1] | a[2]) & (b[1] | b[2]) & (a[3] | b[3]));
    return c;
  endfunction

endpackage

// File: rtl/vc_nibble_slice.sv
// One nibble-wide combination slice; the scheduler time-multiplexes a single instance.
module vc_nibble_slice
  import vc_pkg::*;
(
  input  logic [NIB_W-1:0] a,
  input  logic [NIB_W-1:0] b,
  output logic [NIB_W-1:0] c
);

  assign c = vc_nib(a, b);

endmodule

// File: rtl/vc_slice_sched.sv
// Round-robin scheduler sharing one nibble slice among NREQ requesters,
// sequencing each captured operand pair over NIB beats.
module vc_slice_sched
  import vc_pkg::*;
#(
  parameter  int NREQ = 3,
  parameter  int NIB  = 3,
  localparam int W    = NIB_W * NIB,
  localparam int IDW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [NREQ*W-1:0] req_a,
  input  logic [NREQ*W-1:0] req_b,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [W-1:0]      res_data,
  output logic [IDW-1:0]    res_id,
  output logic              busy
);

  localparam int BW = (NIB > 1) ? $clog2(NIB) : 1;

  state_t           state;
  logic [BW-1:0]    beat;
  logic [IDW-1:0]   ptr;
  logic [IDW-1:0]   id_q;
  logic [W-1:0]     op_a;
  logic [W-1:0]     op_b;
  logic [W-1:0]     res_q;

  logic             grant_found;
  logic [IDW-1:0]   grant_idx;
  logic [IDW-1:0]   cand;
  logic [NIB_W-1:0] nib_a;
  logic [NIB_W-1:0] nib_b;
  logic [NIB_W-1:0] nib_c;

  // Search upward from ptr+1 so the last winner drops to lowest priority.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int i = 1; i <= NREQ; i++) begin
      cand = IDW'((int'(ptr) + i) % NREQ);
      if (!grant_found && req_valid[cand]) begin
        grant_found = 1'b1;
        grant_idx   = cand;
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (state == IDLE && grant_found) req_ready[grant_idx] = 1'b1;
  end

  assign nib_a = op_a[NIB_W*int'(beat) +: NIB_W];
  assign nib_b = op_b[NIB_W*int'(beat) +: NIB_W];

  vc_nibble_slice u_slice (
    .a (nib_a),
    .b (nib_b),
    .c (nib_c)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      beat  <= '0;
      ptr   <= IDW'(NREQ - 1);
      id_q  <= '0;
      op_a  <= '0;
      op_b  <= '0;
      res_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_found) begin
            op_a  <= req_a[int'(grant_idx)*W +: W];
            op_b  <= req_b[int'(grant_idx)*W +: W];
            id_q  <= grant_idx;
            ptr   <= grant_idx;
            beat  <= '0;
            state <= RUN;
          end
        end
        RUN: begin
          res_q[NIB_W*int'(beat) +: NIB_W] <= nib_c;
          if (beat == BW'(NIB - 1)) state <= DONE;
          else                      beat  <= beat + 1'b1;
        end
        DONE: begin
          if (res_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Result ports read zero outside DONE so the consumer never sees stale data.
  assign busy      = (state != IDLE);
  assign res_valid = (state == DONE);
  assign res_data  = res_valid ? res_q : '0;
  assign res_id    = res_valid ? id_q  : '0;

  a_ready_onehot: assert property (@(posedge clk) $onehot0(req_ready));
  a_ready_idle:   assert property (@(posedge clk) (req_ready != '0) |-> (state == IDLE));
  a_res_stable:   assert property (@(posedge clk) disable iff (rst)
                                   (res_valid && !res_ready) |=> $stable(res_data));

endmodule

// File: tb/tb_vc_slice_sched.sv
// Directed testbench for vc_slice_sched with hand-computed expected results.
module tb_vc_slice_sched;

  localparam int NREQ = 3;
  localparam int NIB  = 3;
  localparam int W    = 12;
  localparam int IDW  = 2;

  logic              clk;
  logic              rst;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ*W-1:0] req_a;
  logic [NREQ*W-1:0] req_b;
  logic              res_valid;
  logic              res_ready;
  logic [W-1:0]      res_data;
  logic [IDW-1:0]    res_id;
  logic              busy;

  int vectors;
  int miscompares;

  vc_slice_sched #(.NREQ(NREQ), .NIB(NIB)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_data  (res_data),
    .res_id    (res_id),
    .busy      (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string tag, input logic [35:0] got, input logic [35:0] expd);
    vectors++;
    if (got !== expd) begin
      miscompares++;
      $display("[TB] FAIL %s got=%0h expected=%0h", tag, got, expd);
    end
  endtask

  task automatic applyStimulus(input int idx, input logic [W-1:0] a, input logic [W-1:0] b);
    req_a[idx*W +: W] = a;
    req_b[idx*W +: W] = b;
    req_valid         = NREQ'(1 << idx);
  endtask

  // Called one time unit after a rising edge with the DUT in IDLE.
  task automatic runJob(input int idx, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] expd, input int hold);
    applyStimulus(idx, a, b);
    res_ready = (hold == 0);
    #1;
    checkOutput("accept_ready", 36'(req_ready), 36'(1 << idx));
    @(posedge clk); #1;
    req_valid = '0;
    req_a     = ~req_a;
    req_b     = ~req_b;
    checkOutput("busy_run", 36'(busy), 36'd1);
    for (int k = 2; k <= NIB; k++) begin
      @(posedge clk); #1;
      checkOutput("early_valid", 36'(res_valid), 36'd0);
    end
    @(posedge clk); #1;
    checkOutput("done_valid", 36'(res_valid), 36'd1);
    checkOutput("done_data", 36'(res_data), 36'(expd));
    checkOutput("done_id", 36'(res_id), 36'(idx));
    if (hold > 0) begin
      req_valid = '1;
      for (int h = 0; h < hold; h++) begin
        @(posedge clk); #1;
        checkOutput("hold_valid", 36'(res_valid), 36'd1);
        checkOutput("hold_data", 36'(res_data), 36'(expd));
        checkOutput("hold_id", 36'(res_id), 36'(idx));
        checkOutput("hold_noready", 36'(req_ready), 36'd0);
      end
      res_ready = 1'b1;
    end
    @(posedge clk); #1;
    req_valid = '0;
    res_ready = 1'b0;
    checkOutput("release_valid", 36'(res_valid), 36'd0);
    checkOutput("release_busy", 36'(busy), 36'd0);
  endtask

  initial begin
    int gcount;
    int gid[6];
    int gcyc[6];
    int cur;

    vectors     = 0;
    miscompares = 0;
    rst         = 1'b1;
    req_valid   = '0;
    req_a       = '0;
    req_b       = '0;
    res_ready   = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_valid", 36'(res_valid), 36'd0);
    checkOutput("rst_data", 36'(res_data), 36'd0);
    checkOutput("rst_id", 36'(res_id), 36'd0);
    checkOutput("rst_busy", 36'(busy), 36'd0);
    checkOutput("rst_ready", 36'(req_ready), 36'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    runJob(0, 12'h000, 12'h000, 12'hFFF, 0);
    runJob(1, 12'hFFF, 12'hFFF, 12'h000, 0);
    runJob(2, 12'hEEE, 12'hEEE, 12'h333, 0);
    runJob(2, 12'h123, 12'h000, 12'hEFE, 0);
    runJob(0, 12'h5A5, 12'h3C3, 12'h878, 10);

    // Abort a job from requester 1 mid-RUN; priority must restart at requester 0.
    applyStimulus(1, 12'h456, 12'h789);
    #1;
    checkOutput("abort_accept", 36'(req_ready), 36'b010);
    @(posedge clk); #1;
    req_valid = '0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checkOutput("abort_busy", 36'(busy), 36'd0);
    checkOutput("abort_valid", 36'(res_valid), 36'd0);
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      checkOutput("abort_novalid", 36'(res_valid), 36'd0);
    end

    req_valid = '1;
    res_ready = 1'b1;
    gcount    = 0;
    for (int cyc = 0; cyc < 28; cyc++) begin
      #1;
      if (req_ready != '0) begin
        cur = req_ready[1] ? 1 : (req_ready[2] ? 2 : 0);
        if (gcount < 6) begin
          gid[gcount]  = cur;
          gcyc[gcount] = cyc;
        end
        gcount++;
      end
      @(posedge clk);
    end
    #1;
    req_valid = '0;
    checkOutput("rot_count", 36'(gcount), 36'd6);
    if (gcount >= 6) begin
      for (int i = 0; i < 6; i++) begin
        checkOutput("rot_order", 36'(gid[i]), 36'(i % 3));
        if (i > 0) checkOutput("rot_spacing", 36'(gcyc[i] - gcyc[i-1]), 36'(NIB + 2));
      end
    end
    repeat (10) @(posedge clk);
    #1;
    checkOutput("drain_busy", 36'(busy), 36'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
